simon_uart_sequencer: RTL and testbench

SIMON_UART_SEQUENCER -- requirements
Module: simon_uart_sequencer

---
 rtl/simon_uart_sequencer_pkg.sv | 9 +
 rtl/uart_block_packer.sv | 29 ++
 rtl/simon_uart_sequencer.sv | 128 ++++++++++++
 tb/tb_simon_uart_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_uart_sequencer_pkg.sv
// Shared types and defaults for the UART-fed SIMON block sequencer.
package simon_uart_sequencer_pkg;
  localparam int BLOCK_BYTES_DEF  = 8;
  localparam int DONE_TIMEOUT_DEF = 1024;

  typedef enum logic [2:0] {
    IDLE, LOAD, WAIT_GO, START, CRYPT, UNLOAD
  } seq_state_t;
endpackage

// File: rtl/uart_block_packer.sv
// Block register: packs RX bytes MSB-first, loads the cipher result, and shifts bytes out MSB-first.
module uart_block_packer
  import simon_uart_sequencer_pkg::*;
#(
  parameter int BLOCK_BYTES = BLOCK_BYTES_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     load_byte,
  input  logic [7:0]               byte_in,
  input  logic                     load_word,
  input  logic [8*BLOCK_BYTES-1:0] word_in,
  input  logic                     shift_out,
  output logic [8*BLOCK_BYTES-1:0] word,
  output logic [7:0]               msb_byte
);
  localparam int W = 8 * BLOCK_BYTES;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         word <= '0;
    else if (clear)     word <= '0;
    else if (load_word) word <= word_in;
    else if (load_byte) word <= {word[W-9:0], byte_in};
    else if (shift_out) word <= {word[W-9:0], 8'h00};
  end

  assign msb_byte = word[W-1 -: 8];
endmodule

// File: rtl/simon_uart_sequencer.sv
// Sequencer: collects a block from the RX FIFO, runs it through the cipher core, drains it to the TX FIFO.
module simon_uart_sequencer
  import simon_uart_sequencer_pkg::*;
#(
  parameter int BLOCK_BYTES  = BLOCK_BYTES_DEF,
  parameter int AUTO_START   = 0,
  parameter int DONE_TIMEOUT = DONE_TIMEOUT_DEF
) (
  input  logic                     clk_100MHz,
  input  logic                     reset_n,
  input  logic                     go,
  input  logic                     rx_empty,
  input  logic [7:0]               rx_data,
  output logic                     rd_uart,
  input  logic                     tx_full,
  output logic [7:0]               tx_data,
  output logic                     wr_uart,
  output logic [8*BLOCK_BYTES-1:0] core_din,
  output logic                     core_start,
  input  logic [8*BLOCK_BYTES-1:0] core_dout,
  input  logic                     core_done,
  output logic                     busy,
  output logic                     block_ready,
  output logic                     err,
  output logic [7:0]               blk_cnt
);
  localparam int BW = $clog2(BLOCK_BYTES + 1);
  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(BLOCK_BYTES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(DONE_TIMEOUT - 1);

  seq_state_t    state;
  logic [BW-1:0] byte_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          pop, push, capture, timeout;

  // FWFT handshakes must be combinational so a byte is consumed in the cycle it is offered.
  assign pop     = (state == LOAD)   && !rx_empty;
  assign push    = (state == UNLOAD) && !tx_full;
  assign capture = (state == CRYPT)  && core_done;
  assign timeout = (state == CRYPT)  && !core_done && (tmo_cnt >= TMO_LAST);
  assign rd_uart = pop;
  assign wr_uart = push;

  uart_block_packer #(.BLOCK_BYTES(BLOCK_BYTES)) u_packer (
    .clk       (clk_100MHz),
    .rst_n     (reset_n),
    .clear     (timeout),
    .load_byte (pop),
    .byte_in   (rx_data),
    .load_word (capture),
    .word_in   (core_dout),
    .shift_out (push),
    .word      (core_din),
    .msb_byte  (tx_data)
  );

  // tmo_cnt counts cycles since core_start rose, so the START cycle is included in the budget.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      byte_cnt    <= '0;
      tmo_cnt     <= '0;
      blk_cnt     <= '0;
      err         <= 1'b0;
      core_start  <= 1'b0;
      busy        <= 1'b0;
      block_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= LOAD;
          busy     <= 1'b1;
          byte_cnt <= '0;
        end
        LOAD: if (pop) begin
          if (byte_cnt == LAST_BYTE) begin
            byte_cnt <= '0;
            if (AUTO_START != 0) begin
              state      <= START;
              core_start <= 1'b1;
            end else begin
              state       <= WAIT_GO;
              block_ready <= 1'b1;
              busy        <= 1'b0;
            end
          end else begin
            byte_cnt <= byte_cnt + BW'(1);
          end
        end
        WAIT_GO: if (go) begin
          state       <= START;
          core_start  <= 1'b1;
          block_ready <= 1'b0;
          busy        <= 1'b1;
          err         <= 1'b0;
        end
        START: begin
          state      <= CRYPT;
          core_start <= 1'b0;
          tmo_cnt    <= TW'(1);
        end
        CRYPT: begin
          if (core_done) begin
            state <= UNLOAD;
          end else if (tmo_cnt >= TMO_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        UNLOAD: if (push) begin
          if (byte_cnt == LAST_BYTE) begin
            byte_cnt <= '0;
            state    <= IDLE;
            busy     <= 1'b0;
            blk_cnt  <= blk_cnt + 8'd1;
          end else begin
            byte_cnt <= byte_cnt + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_simon_uart_sequencer.sv
// Bench: manual-start instance driven by table vectors and corner sequences; auto-start instance under random traffic.
module tb_simon_uart_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- manual-start instance ----------------
  logic        rst0_n, go0, rx_empty0, tx_full0, core_done0, rd0, wr0;
  logic        core_start0, busy0, ready0, err0, model_done0, stray_done0;
  logic [7:0]  rx_data0, tx_data0, blk_cnt0;
  logic [63:0] core_din0, core_dout0;
  assign core_done0 = model_done0 | stray_done0;

  simon_uart_sequencer #(.AUTO_START(0)) dut0 (
    .clk_100MHz(clk), .reset_n(rst0_n), .go(go0),
    .rx_empty(rx_empty0), .rx_data(rx_data0), .rd_uart(rd0),
    .tx_full(tx_full0), .tx_data(tx_data0), .wr_uart(wr0),
    .core_din(core_din0), .core_start(core_start0), .core_dout(core_dout0), .core_done(core_done0),
    .busy(busy0), .block_ready(ready0), .err(err0), .blk_cnt(blk_cnt0));

  logic [7:0]  rxq0[$], txq0[$];
  int          start_cnt0 = 0, start_cyc0 = 0, wr_full_viol0 = 0, core_lat0 = 10;
  bit          core_never0 = 0;
  logic [63:0] start_din0 = '0;

  // FIFO models: decisions sampled on the falling edge, queue updates just after the rising edge.
  initial begin
    bit do_rd, do_wr;
    logic [7:0] wb;
    rx_empty0 = 1'b1;
    rx_data0  = 8'h00;
    forever begin
      @(negedge clk);
      do_rd = rd0; do_wr = wr0; wb = tx_data0;
      if (wr0 && tx_full0) wr_full_viol0++;
      if (core_start0) begin
        start_cnt0++;
        start_din0 = core_din0;
        start_cyc0 = cyc;
      end
      @(posedge clk); #1;
      if (do_rd && rxq0.size() > 0) void'(rxq0.pop_front());
      if (do_wr) txq0.push_back(wb);
      #1;
      rx_empty0 = (rxq0.size() == 0);
      rx_data0  = rx_empty0 ? 8'h00 : rxq0[0];
    end
  end

  initial begin
    logic [63:0] d;
    model_done0 = 1'b0;
    core_dout0  = '0;
    forever begin
      @(negedge clk);
      if (core_start0 && !core_never0) begin
        d = core_din0;
        repeat (core_lat0) @(posedge clk);
        #1 model_done0 = 1'b1; core_dout0 = d ^ 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk);
        #1 model_done0 = 1'b0;
      end
    end
  end

  // ---------------- auto-start instance ----------------
  logic        rst1_n, rx_empty1, tx_full1, core_done1, rd1, wr1;
  logic        core_start1, busy1, ready1, err1;
  logic [7:0]  rx_data1, tx_data1, blk_cnt1;
  logic [63:0] core_din1, core_dout1;
  logic        go1 = 1'b0;

  simon_uart_sequencer #(.AUTO_START(1)) dut1 (
    .clk_100MHz(clk), .reset_n(rst1_n), .go(go1),
    .rx_empty(rx_empty1), .rx_data(rx_data1), .rd_uart(rd1),
    .tx_full(tx_full1), .tx_data(tx_data1), .wr_uart(wr1),
    .core_din(core_din1), .core_start(core_start1), .core_dout(core_dout1), .core_done(core_done1),
    .busy(busy1), .block_ready(ready1), .err(err1), .blk_cnt(blk_cnt1));

  localparam int AUTO_BLOCKS = 256;
  logic [7:0] blk1[$], exp1[$];
  int  tx_cnt1 = 0, overlap1 = 0, src_left1 = AUTO_BLOCKS * 8;
  bit  inflight1 = 0, run1 = 0;

  // Reference: output byte i of a block is input byte (i+1) mod 8 XOR A5 (core rotates the block by one byte).
  initial begin
    bit d_rd, d_wr;
    logic [7:0] d_rb, d_wb, e;
    rx_empty1 = 1'b1;
    rx_data1  = 8'h00;
    tx_full1  = 1'b0;
    forever begin
      @(negedge clk);
      d_rd = rd1; d_rb = rx_data1; d_wr = wr1; d_wb = tx_data1;
      if (rd1 && inflight1) overlap1++;
      if (core_start1) inflight1 = 1;
      @(posedge clk); #1;
      if (d_rd) begin
        blk1.push_back(d_rb);
        src_left1--;
        rx_data1 = 8'($urandom);
        if (blk1.size() == 8) begin
          for (int i = 0; i < 8; i++) exp1.push_back(blk1[(i + 1) % 8] ^ 8'hA5);
          blk1.delete();
        end
      end
      if (d_wr) begin
        e = (exp1.size() > 0) ? exp1.pop_front() : 8'hxx;
        chk("auto_tx_byte", {56'h0, d_wb}, {56'h0, e});
        tx_cnt1++;
        if (tx_cnt1 % 8 == 0) inflight1 = 0;
      end
      rx_empty1 = (run1 && src_left1 > 0) ? ($urandom_range(0, 4) == 0) : 1'b1;
      tx_full1  = run1 ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
  end

  initial begin
    logic [63:0] d;
    core_done1 = 1'b0;
    core_dout1 = '0;
    forever begin
      @(negedge clk);
      if (core_start1) begin
        d = core_din1;
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1 core_done1 = 1'b1; core_dout1 = {d[55:0], d[63:56]} ^ {8{8'hA5}};
        @(posedge clk);
        #1 core_done1 = 1'b0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_until(input int what, input int n, input int max_cyc, output bit ok);
    ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      case (what)
        0: ok = ready0;
        1: ok = (txq0.size() >= n);
        2: ok = (rxq0.size() == 0);
        3: ok = err0;
        default: ok = (tx_cnt1 >= n);
      endcase
      if (ok) break;
    end
  endtask

  task automatic push_block0(input logic [63:0] w);
    for (int j = 0; j < 8; j++) rxq0.push_back(w[63 - 8*j -: 8]);
  endtask

  task automatic pulse_go0();
    @(posedge clk); #1 go0 = 1'b1;
    @(posedge clk); #1 go0 = 1'b0;
  endtask

  task automatic grab_tx0(output logic [63:0] w);
    w = '0;
    for (int j = 0; j < 8; j++) begin
      if (txq0.size() > 0) w = {w[55:0], txq0.pop_front()};
      else                 w = {w[55:0], 8'hxx};
    end
  endtask

  typedef struct {
    logic [63:0] din;
    int          lat;
    logic [63:0] exp_tx;
  } vec_t;
  vec_t vecs[4];

  initial begin
    bit ok;
    int s0, nb, v, e_cyc, exp_blk0;
    logic [63:0] got;
    vecs[0] = '{64'h0102030405060708, 10, 64'hFEFDFCFBFAF9F8F7};
    vecs[1] = '{64'h0000000000000000,  1, 64'hFFFFFFFFFFFFFFFF};
    vecs[2] = '{64'hDEADBEEF01234567,  3, 64'h21524110FEDCBA98};
    vecs[3] = '{64'hFF00FF00A5A55A5A, 25, 64'h00FF00FF5A5AA5A5};
    exp_blk0 = 0;
    rst0_n = 1'b0; rst1_n = 1'b0; go0 = 1'b0; tx_full0 = 1'b0; stray_done0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy0, 0);       chk("rst_ready", ready0, 0);
    chk("rst_err", err0, 0);         chk("rst_blk_cnt", blk_cnt0, 0);
    chk("rst_rd", rd0, 0);           chk("rst_wr", wr0, 0);
    chk("rst_start", core_start0, 0); chk("rst_din", core_din0, 0);
    @(posedge clk); #1 rst0_n = 1'b1; rst1_n = 1'b1;

    // table vectors
    for (int i = 0; i < 4; i++) begin
      s0 = start_cnt0; core_lat0 = vecs[i].lat;
      push_block0(vecs[i].din);
      wait_until(0, 0, 100, ok);
      chk("vec_ready", ok, 1);
      chk("vec_no_early_start", start_cnt0 - s0, 0);
      pulse_go0();
      wait_until(1, 8, 200, ok);
      chk("vec_tx_done", ok, 1);
      grab_tx0(got);
      exp_blk0++;
      chk("vec_core_din", start_din0, vecs[i].din);
      chk("vec_tx", got, vecs[i].exp_tx);
      chk("vec_one_start", start_cnt0 - s0, 1);
      repeat (2) @(negedge clk);
      chk("vec_blk_cnt", blk_cnt0, exp_blk0);
      chk("vec_no_extra_tx", txq0.size(), 0);
    end

    // go while the block is still partial is dropped
    s0 = start_cnt0; core_lat0 = 4;
    for (int j = 1; j <= 4; j++) rxq0.push_back(8'(8'h10 + j));
    wait_until(2, 0, 50, ok);
    pulse_go0();
    repeat (20) @(negedge clk);
    chk("early_go_no_start", start_cnt0 - s0, 0);
    chk("early_go_not_ready", ready0, 0);
    for (int j = 5; j <= 8; j++) rxq0.push_back(8'(8'h10 + j));
    wait_until(0, 0, 50, ok);
    repeat (5) @(negedge clk);
    chk("early_go_still_waiting", start_cnt0 - s0, 0);
    pulse_go0();
    wait_until(1, 8, 200, ok);
    grab_tx0(got);
    exp_blk0++;
    chk("early_go_din", start_din0, 64'h1112131415161718);
    chk("early_go_tx", got, 64'hEEEDECEBEAE9E8E7);

    // TX backpressure in the middle of UNLOAD
    core_lat0 = 5;
    push_block0(64'h8877665544332211);
    wait_until(0, 0, 100, ok);
    pulse_go0();
    wait_until(1, 2, 100, ok);
    @(posedge clk); #1 tx_full0 = 1'b1;
    @(negedge clk);
    nb = txq0.size(); v = wr_full_viol0;
    repeat (19) @(negedge clk);
    chk("bp_partial", nb < 8, 1);
    chk("bp_hold", txq0.size(), nb);
    chk("bp_wr_while_full", wr_full_viol0 - v, 0);
    @(posedge clk); #1 tx_full0 = 1'b0;
    wait_until(1, 8, 100, ok);
    grab_tx0(got);
    exp_blk0++;
    chk("bp_tx", got, 64'h778899AABBCCDDEE);
    repeat (4) @(negedge clk);
    chk("bp_no_dup", txq0.size(), 0);

    // core never answers
    core_never0 = 1;
    push_block0(64'hA1A2A3A4A5A6A7A8);
    wait_until(0, 0, 100, ok);
    pulse_go0();
    wait_until(3, 0, 1200, ok);
    e_cyc = cyc;
    chk("tmo_err", ok, 1);
    chk("tmo_latency", e_cyc - start_cyc0, 1024);
    chk("tmo_idle", busy0, 0);
    repeat (5) @(negedge clk);
    chk("tmo_no_tx", txq0.size(), 0);
    chk("tmo_err_sticky", err0, 1);

    // stray done outside CRYPT, then err cleared by the next go
    core_never0 = 0; core_lat0 = 2;
    push_block0(64'h0F1E2D3C4B5A6978);
    wait_until(0, 0, 100, ok);
    chk("sticky_at_ready", err0, 1);
    @(posedge clk); #1 stray_done0 = 1'b1;
    @(posedge clk); #1 stray_done0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray_done_ready", ready0, 1);
    chk("stray_done_no_tx", txq0.size(), 0);
    pulse_go0();
    @(negedge clk);
    chk("err_cleared_by_go", err0, 0);
    wait_until(1, 8, 100, ok);
    grab_tx0(got);
    exp_blk0++;
    chk("post_tmo_tx", got, 64'hF0E1D2C3B4A59687);
    repeat (2) @(negedge clk);
    chk("post_tmo_blk_cnt", blk_cnt0, exp_blk0);

    // reset in the middle of LOAD
    for (int j = 1; j <= 5; j++) rxq0.push_back(8'(8'hC0 + j));
    wait_until(2, 0, 50, ok);
    @(posedge clk); #1 rst0_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_din", core_din0, 0);   chk("mid_rst_blk_cnt", blk_cnt0, 0);
    chk("mid_rst_busy", busy0, 0);      chk("mid_rst_rd", rd0, 0);
    chk("mid_rst_start", core_start0, 0);
    @(posedge clk); #1 rst0_n = 1'b1;
    s0 = start_cnt0;
    push_block0(64'h3132333435363738);
    wait_until(0, 0, 100, ok);
    chk("mid_rst_no_restart", start_cnt0 - s0, 0);
    pulse_go0();
    wait_until(1, 8, 100, ok);
    grab_tx0(got);
    chk("mid_rst_din_fresh", start_din0, 64'h3132333435363738);
    chk("mid_rst_tx", got, 64'hCECDCCCBCAC9C8C7);
    repeat (2) @(negedge clk);
    chk("mid_rst_blk_cnt_after", blk_cnt0, 1);

    // auto-start under random traffic
    run1 = 1;
    wait_until(4, AUTO_BLOCKS * 8, 40000, ok);
    chk("auto_done", ok, 1);
    repeat (4) @(negedge clk);
    chk("auto_tx_count", tx_cnt1, AUTO_BLOCKS * 8);
    chk("auto_blk_cnt_wrap", blk_cnt1, 0);
    chk("auto_no_overlap", overlap1, 0);
    chk("auto_err", err1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
